// File: rtl/top_level.sv
// Instruction fetch stage: 32-bit PC stepping through a fixed instruction ROM,
// with register-field extraction and I/S/B immediate decode of the fetched word.

module top_level_imm_decode (
  input  logic [31:0] i_instr,
  output logic [4:0]  o_rd,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [11:0] o_imm
);
  logic [6:0] w_opcode;
  logic       w_unused;

  assign w_opcode = i_instr[6:0];
  assign o_rd     = i_instr[11:7];
  assign o_rs1    = i_instr[19:15];
  assign o_rs2    = i_instr[24:20];
  // funct3 plays no part in field or immediate extraction
  assign w_unused = ^i_instr[14:12];

  always_comb begin
    o_imm = '0;
    case (w_opcode)
      7'b0010011, 7'b0000011, 7'b1100111: o_imm = i_instr[31:20];
      7'b0100011: o_imm = {i_instr[31:25], i_instr[11:7]};
      7'b1100011: o_imm = {i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8]};
      default:    o_imm = '0;
    endcase
  end
endmodule

module top_level #(
  parameter int unsigned IMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] instr_test,
  output logic [4:0]  r_d,
  output logic [4:0]  rs_1,
  output logic [4:0]  rs_2,
  output logic [11:0] IMM
);
  localparam int unsigned AW = $clog2(IMEM_WORDS);

  logic [31:0]   r_pc;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_instr;
  logic          w_unused;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pc <= '0;
    else     r_pc <= r_pc + 32'd4;
  end

  // Only the word index addresses the ROM, so fetch wraps every IMEM_WORDS words
  assign w_idx    = r_pc[AW+1:2];
  assign w_unused = ^{r_pc[31:AW+2], r_pc[1:0]};

  always_comb begin
    w_instr = 32'h0000_0013;
    case (w_idx)
      AW'(0):  w_instr = 32'h0050_0093;
      AW'(1):  w_instr = 32'hFFF0_8113;
      AW'(2):  w_instr = 32'h0020_81B3;
      AW'(3):  w_instr = 32'h0030_2423;
      AW'(4):  w_instr = 32'h0080_2203;
      default: w_instr = 32'h0000_0013;
    endcase
  end

  assign instr_test = w_instr;

  top_level_imm_decode u_dec (
    .i_instr (w_instr),
    .o_rd    (r_d),
    .o_rs1   (rs_1),
    .o_rs2   (rs_2),
    .o_imm   (IMM)
  );
endmodule

// File: tb/tb_top_level.sv
// Directed bench for the fetch stage: reset, full ROM walk with wrap,
// asynchronous mid-run reset and immediate decode of individual formats.

module tb_top_level;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_test;
  logic [4:0]  r_d, rs_1, rs_2;
  logic [11:0] IMM;

  logic [31:0] dec_instr;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2;
  logic [11:0] dec_imm;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  top_level #(.IMEM_WORDS(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_test (instr_test),
    .r_d        (r_d),
    .rs_1       (rs_1),
    .rs_2       (rs_2),
    .IMM        (IMM)
  );

  top_level_imm_decode dec (
    .i_instr (dec_instr),
    .o_rd    (dec_rd),
    .o_rs1   (dec_rs1),
    .o_rs2   (dec_rs2),
    .o_imm   (dec_imm)
  );

  // {instr, rd, rs1, rs2, imm}; index 5 stands for every nop word
  function automatic logic [58:0] exp_word(input int w);
    case (w)
      0:       return {32'h00500093, 5'd1, 5'd0, 5'd5,  12'h005};
      1:       return {32'hFFF08113, 5'd2, 5'd1, 5'd31, 12'hFFF};
      2:       return {32'h002081B3, 5'd3, 5'd1, 5'd2,  12'h000};
      3:       return {32'h00302423, 5'd8, 5'd0, 5'd3,  12'h008};
      4:       return {32'h00802203, 5'd4, 5'd0, 5'd8,  12'h008};
      default: return {32'h00000013, 5'd0, 5'd0, 5'd0,  12'h000};
    endcase
  endfunction

  task automatic test_reset();
    logic [58:0] got;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    got = {instr_test, r_d, rs_1, rs_2, IMM};
    n_total++;
    if (got !== exp_word(0)) $display("FAIL reset_held: got %h expected %h", got, exp_word(0));
    else n_pass++;
    rst = 1'b0;
    #1;
    got = {instr_test, r_d, rs_1, rs_2, IMM};
    n_total++;
    if (got !== exp_word(0)) $display("FAIL reset_release: got %h expected %h", got, exp_word(0));
    else n_pass++;
  endtask

  task automatic test_sequence();
    logic [58:0] got;
    logic [58:0] exp;
    int          w;
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk);
      #1;
      w   = k % 64;
      exp = exp_word(w < 5 ? w : 5);
      got = {instr_test, r_d, rs_1, rs_2, IMM};
      n_total++;
      if (got !== exp) $display("FAIL seq_edge%0d: got %h expected %h", k, got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    logic [58:0] got;
    repeat (3) @(posedge clk);
    #1;
    got = {instr_test, r_d, rs_1, rs_2, IMM};
    n_total++;
    if (got !== exp_word(3)) $display("FAIL pre_async_word3: got %h expected %h", got, exp_word(3));
    else n_pass++;
    #3 rst = 1'b1;
    #1;
    got = {instr_test, r_d, rs_1, rs_2, IMM};
    n_total++;
    if (got !== exp_word(0)) $display("FAIL async_reset_immediate: got %h expected %h", got, exp_word(0));
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    got = {instr_test, r_d, rs_1, rs_2, IMM};
    n_total++;
    if (got !== exp_word(0)) $display("FAIL async_reset_hold: got %h expected %h", got, exp_word(0));
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    got = {instr_test, r_d, rs_1, rs_2, IMM};
    n_total++;
    if (got !== exp_word(0)) $display("FAIL async_release: got %h expected %h", got, exp_word(0));
    else n_pass++;
    @(posedge clk);
    #1;
    got = {instr_test, r_d, rs_1, rs_2, IMM};
    n_total++;
    if (got !== exp_word(1)) $display("FAIL async_first_edge: got %h expected %h", got, exp_word(1));
    else n_pass++;
  endtask

  task automatic test_imm_decode();
    logic [31:0] vin [8];
    logic [11:0] vimm [8];
    vin[0] = 32'hFE208EE3; vimm[0] = 12'hFFE; // beq x1,x2,-4
    vin[1] = 32'h80000063; vimm[1] = 12'h800; // B-type sign bit only
    vin[2] = 32'h000000E3; vimm[2] = 12'h400; // B-type instr[7] only
    vin[3] = 32'hFE112E23; vimm[3] = 12'hFFC; // sw x1,-4(x2)
    vin[4] = 32'hFFF00067; vimm[4] = 12'hFFF; // jalr I-type
    vin[5] = 32'hFFF0006F; vimm[5] = 12'h000; // jal: not decoded
    vin[6] = 32'hFFF02083; vimm[6] = 12'hFFF; // lw x1,-1(x0)
    vin[7] = 32'hFFFFFFB3; vimm[7] = 12'h000; // R-type all ones
    for (int i = 0; i < 8; i++) begin
      dec_instr = vin[i];
      #1;
      n_total++;
      if (dec_imm !== vimm[i])
        $display("FAIL imm_%h: got %h expected %h", vin[i], dec_imm, vimm[i]);
      else n_pass++;
    end
    dec_instr = 32'hFE208EE3;
    #1;
    n_total++;
    if ({dec_rs1, dec_rs2, dec_rd} !== {5'd1, 5'd2, 5'd29})
      $display("FAIL btype_fields: got rs1=%0d rs2=%0d rd=%0d expected rs1=1 rs2=2 rd=29",
               dec_rs1, dec_rs2, dec_rd);
    else n_pass++;
  endtask

  initial begin
    rst       = 1'b1;
    dec_instr = 32'h00000013;
    test_reset();
    test_sequence();
    test_async_reset();
    test_imm_decode();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/top_level.md
TOP_LEVEL -- requirements
Module: top_level

Interface
REQ-001 SHALL have one parameter: IMEM_WORDS, default 64, instruction ROM depth in 32-bit words (power of two).
REQ-002 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port instr_test, output, 32 bits: instruction currently fetched.
REQ-005 SHALL have port r_d, output, 5 bits: instr_test[11:7].
REQ-006 SHALL have port rs_1, output, 5 bits: instr_test[19:15].
REQ-007 SHALL have port rs_2, output, 5 bits: instr_test[24:20].
REQ-008 SHALL have port IMM, output, 12 bits: decoded immediate per REQ-013.

Function
REQ-009 SHALL hold a 32-bit program counter (PC) register, the only sequential state.
REQ-010 SHALL add 4 to PC on every rising clk edge while rst is low; 32-bit wrap-around, no stall or branch.
REQ-011 SHALL read the ROM combinationally: instr_test = ROM[PC[log2(IMEM_WORDS)+1:2]]; PC[1:0] ignored. The fetch index wraps to word 0 after word IMEM_WORDS-1 (PC 0x100 at default depth).
REQ-012 SHALL hold these ROM contents (hex): word0 00500093 (addi x1,x0,5); word1 FFF08113 (addi x2,x1,-1); word2 002081B3 (add x3,x1,x2); word3 00302423 (sw x3,8(x0)); word4 00802203 (lw x4,8(x0)); all other words 00000013 (nop). The ROM is read-only.
REQ-013 SHALL decode IMM combinationally from opcode instr_test[6:0]:
- 0010011, 0000011, 1100111 (I-type): instr[31:20].
- 0100011 (S-type): {instr[31:25], instr[11:7]}.
- 1100011 (B-type): {instr[31], instr[7], instr[30:25], instr[11:8]}.
- any other opcode: 12'h000.
REQ-014 SHALL drive r_d, rs_1 and rs_2 as raw bit slices for every format, with no zeroing for unused fields.
REQ-015 SHALL update all outputs within the same cycle as a PC change (zero added latency from PC to outputs); no output registers.
REQ-016 SHALL produce no X or Z on any output after reset has been applied once.

Reset
REQ-017 SHALL force PC to 32'h0000_0000 immediately when rst rises, independent of clk.
REQ-018 SHALL hold PC at 0 while rst is high, including across clk edges.
REQ-019 SHALL drive word-0 values during reset: instr_test=00500093, r_d=1, rs_1=0, rs_2=5, IMM=005.
REQ-020 SHALL, when reset is asserted mid-run, restart fetch at word 0. The first increment occurs at the first rising edge with rst low.

Verification
REQ-021 Reset check: assert rst, then release it -> instr_test=00500093, r_d=1, rs_1=0, rs_2=5, IMM=005.
REQ-022 Edge 1 after release -> instr_test=FFF08113, r_d=2, rs_1=1, rs_2=31, IMM=FFF.
REQ-023 Edge 2 -> 002081B3, r_d=3, rs_1=1, rs_2=2, IMM=000 (R-type). Edge 3 -> 00302423, r_d=8, rs_1=0, rs_2=3, IMM=008 (S-type). Edge 4 -> 00802203, r_d=4, IMM=008.
REQ-024 Edge 5 through edge 63 -> 00000013, IMM=000. Edge 64 -> wraps to 00500093.
REQ-025 Assert rst asynchronously between edges while at word 3 -> outputs return to word 0 before the next clk edge. They stay at word 0 while rst is high.
REQ-026 B-type decode: force the ROM word to FE208EE3 (beq x1,x2,-4) -> IMM=FFE, rs_1=1, rs_2=2.
